// File: rtl/seg_pkg.sv
// Shared types and constants for the 8-digit multiplexed 7-segment scan path.
package seg_pkg;
   localparam int         NUM_DIGITS = 8;
   localparam logic [7:0] ANODE_OFF  = 8'hFF;

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

   typedef struct packed {
      logic [2:0] addr;
      logic [3:0] data;
   } wr_req_t;

   // Active-low enable for one digit, or all dark when that digit is masked.
   function automatic logic [7:0] anode_sel(input logic [2:0] idx, input logic [7:0] mask);
      return mask[idx] ? ANODE_OFF : ~(8'b1 << idx);
   endfunction
endpackage

// File: rtl/seg_digit_buffer.sv
// Double-buffered digit store: writes land in shadow, a copy publishes shadow to active.
module seg_digit_buffer
   import seg_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  wr_req_t    wr_req,
   input  logic       copy,
   input  logic [2:0] rd_addr,
   output logic [3:0] rd_data
);
   logic [NUM_DIGITS-1:0][3:0] shadow;
   logic [NUM_DIGITS-1:0][3:0] active;

   // The copy takes the pre-write shadow, so a same-cycle write waits for the next commit.
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow <= '0;
         active <= '0;
      end else begin
         if (copy)  active <= shadow;
         if (wr_en) shadow[wr_req.addr] <= wr_req.data;
      end
   end

   // Bypass so the digit latched in the copy cycle already shows the published value.
   assign rd_data = copy ? shadow[rd_addr] : active[rd_addr];
endmodule

// File: rtl/seg_scan_scheduler.sv
// Digit scan sequencer: slot timing, dead-time blanking, write arbitration, frame-coherent commit.
module seg_scan_scheduler
   import seg_pkg::*;
#(
   parameter int TICK_DIV  = 100000,
   parameter int BLANK_CYC = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       a_valid,
   output logic       a_ready,
   input  logic [2:0] a_addr,
   input  logic [3:0] a_data,
   input  logic       b_valid,
   output logic       b_ready,
   input  logic [2:0] b_addr,
   input  logic [3:0] b_data,
   input  logic       commit,
   input  logic [7:0] blank_mask,
   output logic [7:0] anode,
   output logic [3:0] digit_code,
   output logic [2:0] digit_idx,
   output logic       frame_start,
   output logic       commit_done
);
   localparam int            CW         = $clog2(TICK_DIV);
   localparam logic [CW-1:0] CNT_LAST   = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic          pending;

   logic          a_fire, b_fire, wr_en, copy, enter_blank;
   logic [2:0]    nxt_idx;
   logic [3:0]    rd_data;
   wr_req_t       wr_req;

   assign a_ready = ~reset;
   assign b_ready = ~reset & ~a_valid;
   assign a_fire  = a_valid & a_ready;
   assign b_fire  = b_valid & b_ready;
   assign wr_en   = a_fire | b_fire;
   assign wr_req.addr = a_fire ? a_addr : b_addr;
   assign wr_req.data = a_fire ? a_data : b_data;

   assign enter_blank = enable & ((state == IDLE) | ((state == SHOW) & (cnt == CNT_LAST)));
   assign nxt_idx     = (state == IDLE) ? 3'd0 : idx + 3'd1;
   assign copy        = enter_blank & (nxt_idx == 3'd0) & pending;

   seg_digit_buffer u_buf (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_req  (wr_req),
      .copy    (copy),
      .rd_addr (nxt_idx),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         idx         <= '0;
         pending     <= 1'b0;
         anode       <= ANODE_OFF;
         digit_code  <= '0;
         digit_idx   <= '0;
         frame_start <= 1'b0;
         commit_done <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         commit_done <= 1'b0;
         pending     <= commit | (pending & ~copy);
         if (!enable) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            anode     <= ANODE_OFF;
            digit_idx <= '0;
         end else if (enter_blank) begin
            // New code is latched while anodes are dark, so no ghosting across slots.
            state       <= BLANK;
            cnt         <= '0;
            idx         <= nxt_idx;
            anode       <= ANODE_OFF;
            digit_code  <= rd_data;
            digit_idx   <= nxt_idx;
            frame_start <= (nxt_idx == 3'd0);
            commit_done <= copy;
         end else begin
            cnt <= cnt + 1'b1;
            if (state == BLANK && cnt == BLANK_LAST) state <= SHOW;
            anode <= (state == SHOW || cnt == BLANK_LAST) ? anode_sel(idx, blank_mask) : ANODE_OFF;
         end
      end
   end
endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Self-checking bench: frame-time reference model plus directed and randomized scenarios.
module tb_seg_scan_scheduler;
   localparam int TD = 10;
   localparam int BC = 2;
   localparam int FRAME = 8 * TD;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       a_valid = 1'b0, b_valid = 1'b0, commit = 1'b0;
   logic [2:0] a_addr = '0, b_addr = '0;
   logic [3:0] a_data = '0, b_data = '0;
   logic [7:0] blank_mask = '0;
   logic       a_ready, b_ready, frame_start, commit_done;
   logic [7:0] anode;
   logic [3:0] digit_code;
   logic [2:0] digit_idx;

   int n_chk = 0;
   int n_fail = 0;

   seg_scan_scheduler #(.TICK_DIV(TD), .BLANK_CYC(BC)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .commit(commit), .blank_mask(blank_mask),
      .anode(anode), .digit_code(digit_code), .digit_idx(digit_idx),
      .frame_start(frame_start), .commit_done(commit_done)
   );

   always #5 clk = ~clk;

   // Reference model: position is elapsed cycles since the frame began.
   logic [3:0] m_sh [8];
   logic [3:0] m_act [8];
   bit         m_run, m_pend;
   int         m_t;
   logic [7:0] e_an;
   logic [3:0] e_code;
   logic [2:0] e_idx;
   logic       e_fs, e_cd;

   always @(posedge clk) begin
      bit nf;
      if (reset) begin
         m_run = 0; m_t = 0; m_pend = 0;
         for (int i = 0; i < 8; i++) begin m_sh[i] = '0; m_act[i] = '0; end
         e_an = 8'hFF; e_code = '0; e_idx = '0; e_fs = 0; e_cd = 0;
      end else begin
         e_fs = 0; e_cd = 0; nf = 0;
         if (!enable) begin
            m_run = 0; m_t = 0; e_idx = '0;
         end else if (!m_run) begin
            m_run = 1; m_t = 0; nf = 1;
         end else begin
            m_t = (m_t + 1) % FRAME;
            nf = (m_t == 0);
         end
         if (nf) begin
            e_fs = 1;
            if (m_pend) begin
               for (int i = 0; i < 8; i++) m_act[i] = m_sh[i];
               m_pend = 0; e_cd = 1;
            end
         end
         if (m_run && (m_t % TD) == 0) begin
            e_idx  = 3'(m_t / TD);
            e_code = m_act[e_idx];
         end
         if (commit) m_pend = 1;
         if (a_valid) m_sh[a_addr] = a_data;
         else if (b_valid) m_sh[b_addr] = b_data;
         if (!m_run || (m_t % TD) < BC) e_an = 8'hFF;
         else e_an = blank_mask[e_idx] ? 8'hFF : ~(8'b1 << e_idx);
      end
   end

   wire [16:0] exp_vec = {e_an, e_code, e_idx, e_fs, e_cd};
   wire [16:0] obs_vec = {anode, digit_code, digit_idx, frame_start, commit_done};

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_chk++;
         if (anode !== 8'hFF || frame_start !== 1'b0) begin
            n_fail++; $display("FAIL reset_hold anode=%h fs=%b want FF/0", anode, frame_start);
         end
      end
      reset = 1'b0;
      @(posedge clk); #1;
      n_chk++;
      if (frame_start !== 1'b1 || anode !== 8'hFF || digit_idx !== 3'd0) begin
         n_fail++; $display("FAIL reset_first_frame fs=%b anode=%h idx=%0d want 1/FF/0", frame_start, anode, digit_idx);
      end
   endtask

   task automatic test_free_run();
      int fs_cnt = 0;
      for (int i = 1; i <= 2 * FRAME; i++) begin
         int t, s;
         logic [7:0] want;
         @(posedge clk); #1;
         n_chk++;
         if (obs_vec !== exp_vec) begin
            n_fail++; $display("FAIL free_run_model got %h want %h", obs_vec, exp_vec);
         end
         t = i % FRAME; s = t / TD;
         want = ((t % TD) < BC) ? 8'hFF : ~(8'b1 << s);
         n_chk++;
         if (anode !== want) begin
            n_fail++; $display("FAIL free_run_anode t=%0d anode=%h want %h", t, anode, want);
         end
         if (frame_start) fs_cnt++;
      end
      n_chk++;
      if (fs_cnt != 2) begin
         n_fail++; $display("FAIL free_run_fs_count got %0d want 2", fs_cnt);
      end
   endtask

   task automatic test_arbitration();
      bit seen = 0;
      a_valid = 1; a_addr = 3'd3; a_data = 4'd5;
      b_valid = 1; b_addr = 3'd3; b_data = 4'd9;
      #1;
      n_chk++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         n_fail++; $display("FAIL arb_both a_ready=%b b_ready=%b want 1/0", a_ready, b_ready);
      end
      @(posedge clk); #1;
      a_valid = 0;
      #1;
      n_chk++;
      if (b_ready !== 1'b1) begin
         n_fail++; $display("FAIL arb_b_alone b_ready=%b want 1", b_ready);
      end
      @(posedge clk); #1;
      b_valid = 0; commit = 1;
      @(posedge clk); #1;
      commit = 0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         @(posedge clk); #1;
         n_chk++;
         if (obs_vec !== exp_vec) begin
            n_fail++; $display("FAIL arb_model got %h want %h", obs_vec, exp_vec);
         end
         if (seen && digit_idx == 3'd3 && anode == 8'hF7) begin
            n_chk++;
            if (digit_code !== 4'd9) begin
               n_fail++; $display("FAIL arb_b_last digit_code=%0d want 9", digit_code);
            end
            break;
         end
         if (commit_done) seen = 1;
      end
   endtask

   task automatic test_commit();
      bit done = 0;
      for (int i = 0; i < 2 * FRAME && !(m_run && m_t == 20); i++) @(posedge clk);
      #1;
      a_valid = 1; a_addr = 3'd0; a_data = 4'd7; commit = 1;
      @(posedge clk); #1;
      a_valid = 0; commit = 0;
      for (int i = 0; i < 2 * FRAME && !done; i++) begin
         n_chk++;
         if (obs_vec !== exp_vec) begin
            n_fail++; $display("FAIL commit_model got %h want %h", obs_vec, exp_vec);
         end
         n_chk++;
         if (frame_start) begin
            done = 1;
            if (commit_done !== 1'b1 || digit_code !== 4'd7) begin
               n_fail++; $display("FAIL commit_apply cd=%b code=%0d want 1/7", commit_done, digit_code);
            end
         end else if (commit_done !== 1'b0 || digit_code === 4'd7) begin
            n_fail++; $display("FAIL commit_early cd=%b code=%0d want 0/not 7", commit_done, digit_code);
         end
         if (!done) begin @(posedge clk); #1; end
      end
      n_chk++;
      if (!done) begin n_fail++; $display("FAIL commit_timeout no frame_start seen"); end
   endtask

   task automatic test_enable();
      for (int i = 0; i < 2 * FRAME && !(m_run && m_t == 45); i++) begin @(posedge clk); #1; end
      enable = 0;
      @(posedge clk); #1;
      n_chk++;
      if (anode !== 8'hFF || digit_idx !== 3'd0 || frame_start !== 1'b0) begin
         n_fail++; $display("FAIL enable_drop anode=%h idx=%0d fs=%b want FF/0/0", anode, digit_idx, frame_start);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_chk++;
         if (obs_vec !== exp_vec) begin
            n_fail++; $display("FAIL enable_idle got %h want %h", obs_vec, exp_vec);
         end
      end
      enable = 1;
      @(posedge clk); #1;
      n_chk++;
      if (frame_start !== 1'b1 || digit_idx !== 3'd0) begin
         n_fail++; $display("FAIL enable_restart fs=%b idx=%0d want 1/0", frame_start, digit_idx);
      end
   endtask

   task automatic test_mask();
      blank_mask = 8'h04;
      for (int i = 1; i < FRAME; i++) begin
         int s;
         logic [7:0] want;
         @(posedge clk); #1;
         s = i / TD;
         want = ((i % TD) < BC || s == 2) ? 8'hFF : ~(8'b1 << s);
         n_chk++;
         if (anode !== want || obs_vec !== exp_vec) begin
            n_fail++; $display("FAIL mask_slot t=%0d anode=%h want %h (vec %h/%h)", i, anode, want, obs_vec, exp_vec);
         end
      end
      blank_mask = 8'h00;
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         n_chk++;
         if (obs_vec !== exp_vec) begin
            n_fail++; $display("FAIL random_model cyc=%0d got %h want %h", i, obs_vec, exp_vec);
         end
         reset   = ($urandom_range(399) == 0);
         if ($urandom_range(49) == 0) enable = ~enable;
         else if (!enable && $urandom_range(3) == 0) enable = 1;
         if ($urandom_range(29) == 0) blank_mask = 8'($urandom_range(255));
         commit  = ($urandom_range(19) == 0);
         a_valid = ($urandom_range(3) == 0);
         b_valid = ($urandom_range(2) == 0);
         a_addr  = 3'($urandom_range(7)); a_data = 4'($urandom_range(15));
         b_addr  = 3'($urandom_range(7)); b_data = 4'($urandom_range(15));
         #1;
         n_chk++;
         if (a_ready !== ~reset || b_ready !== (~reset & ~a_valid)) begin
            n_fail++; $display("FAIL random_ready a=%b b=%b rst=%b av=%b", a_ready, b_ready, reset, a_valid);
         end
      end
      reset = 0; commit = 0; a_valid = 0; b_valid = 0;
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_arbitration();
      test_commit();
      test_enable();
      test_mask();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
